bullet_ctrl: RTL and testbench



---
 rtl/bullet_ctrl_pkg.sv | 25 ++
 rtl/bullet_ctrl.sv | 154 +++++++++++++++
 tb/tb_bullet_ctrl.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bullet_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// bullet_ctrl_pkg
// Shared playfield geometry and the bullet FSM state type. The geometry values
// are the defaults for the bullet_ctrl parameters. bullet_state_t is visible to
// the enemy-side responder and to the testbench.
// -----------------------------------------------------------------------------
package bullet_ctrl_pkg;

  localparam int CFG_HRES            = 1280;
  localparam int CFG_VRES            = 720;
  localparam int CFG_BULLET_W        = 4;
  localparam int CFG_BULLET_H        = 16;
  localparam int CFG_BULLET_SPEED    = 16;
  localparam int CFG_PADDLE_W        = 50;
  localparam int CFG_PADDLE_H        = 20;
  localparam int CFG_COOLDOWN_FRAMES = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLY      = 2'd1,
    QUERY    = 2'd2,
    COOLDOWN = 2'd3
  } bullet_state_t;

endpackage

// File: rtl/bullet_ctrl.sv
// -----------------------------------------------------------------------------
// bullet_ctrl
// Player-bullet controller. It spawns one bullet above the paddle when fire is
// held at a frame tick and moves the bullet up once per frame. After each move
// it runs a req/ack hit query against the enemy formation. It also produces the
// bullet pixel-enable for the video mixer.
//
// Ports
//   clk, rst_n          pixel clock, asynchronous active-low reset
//   frame_tick          one-cycle pulse per frame (start of vblank)
//   fire                fire button level (synchronized); holding it auto-fires
//   game_over           kills the bullet and holds the block in IDLE
//   paddle_x            paddle left edge
//   hit_req/x/y         hit query to the formation; x/y stay stable until ack
//   hit_ack, hit_kill   responder done pulse; kill=1 means an enemy was hit
//   px, py              current scan position
//   bullet_on           current pixel is bullet (1-cycle latency from px/py)
//   active              bullet exists (FLY or QUERY)
//   shots               bullets spawned since reset, wraps at 2^16
// -----------------------------------------------------------------------------
module bullet_ctrl
  import bullet_ctrl_pkg::*;
#(
  parameter int HRES            = CFG_HRES,
  parameter int VRES            = CFG_VRES,
  parameter int BULLET_W        = CFG_BULLET_W,
  parameter int BULLET_H        = CFG_BULLET_H,
  parameter int BULLET_SPEED    = CFG_BULLET_SPEED,
  parameter int PADDLE_W        = CFG_PADDLE_W,
  parameter int PADDLE_H        = CFG_PADDLE_H,
  parameter int COOLDOWN_FRAMES = CFG_COOLDOWN_FRAMES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_tick,
  input  logic        fire,
  input  logic        game_over,
  input  logic [10:0] paddle_x,
  output logic        hit_req,
  output logic [10:0] hit_x,
  output logic [9:0]  hit_y,
  input  logic        hit_ack,
  input  logic        hit_kill,
  input  logic [10:0] px,
  input  logic [9:0]  py,
  output logic        bullet_on,
  output logic        active,
  output logic [15:0] shots
);

  // Counter is wide enough to hold COOLDOWN_FRAMES, and at least 1 bit wide.
  localparam int                CD_W      = $clog2(COOLDOWN_FRAMES + 2);
  localparam logic [CD_W-1:0]   CD_LOAD   = CD_W'(COOLDOWN_FRAMES);
  localparam logic [CD_W-1:0]   CD_ONE    = CD_W'(1);
  localparam logic [10:0]       SPAWN_OFS = 11'(PADDLE_W / 2 - BULLET_W / 2);
  localparam logic [9:0]        SPAWN_Y   = 10'(VRES - PADDLE_H - BULLET_H);
  localparam logic [9:0]        SPEED     = 10'(BULLET_SPEED);

  bullet_state_t   state;
  logic [10:0]     x;
  logic [9:0]      y;
  logic [CD_W-1:0] cd_cnt;

  // x/y are only written when the bullet spawns or moves. While the block is in
  // QUERY they are frozen, so the query coordinates come straight from them and
  // remain registered outputs.
  assign hit_x = x;
  assign hit_y = y;

  // NOTE: sequential state uses non-blocking assignments only, and every
  // register gets a value in the asynchronous reset branch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      x       <= '0;
      y       <= '0;
      cd_cnt  <= '0;
      shots   <= '0;
      hit_req <= 1'b0;
      active  <= 1'b0;
    end else if (game_over) begin
      // game_over overrides everything, including an ack in the same cycle.
      // An outstanding request is abandoned.
      state   <= IDLE;
      hit_req <= 1'b0;
      active  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (frame_tick && fire) begin
            x      <= paddle_x + SPAWN_OFS;
            y      <= SPAWN_Y;
            shots  <= shots + 16'd1;
            active <= 1'b1;
            state  <= FLY;
          end
        end
        FLY: begin
          if (frame_tick) begin
            // Check for underflow before subtracting, so y never wraps.
            if (y < SPEED) begin
              active <= 1'b0;
              cd_cnt <= CD_LOAD;
              state  <= COOLDOWN;
            end else begin
              y       <= y - SPEED;
              hit_req <= 1'b1;
              state   <= QUERY;
            end
          end
        end
        QUERY: begin
          // A frame_tick here is dropped on purpose: the bullet moves only
          // from FLY.
          if (hit_ack) begin
            hit_req <= 1'b0;
            if (hit_kill) begin
              active <= 1'b0;
              cd_cnt <= CD_LOAD;
              state  <= COOLDOWN;
            end else begin
              state  <= FLY;
            end
          end
        end
        COOLDOWN: begin
          // A zero load exits on the next cycle. Otherwise the block leaves on
          // the tick that brings the counter to zero.
          if (cd_cnt == '0) begin
            state <= IDLE;
          end else if (frame_tick) begin
            cd_cnt <= cd_cnt - CD_ONE;
            if (cd_cnt == CD_ONE) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Draw compare. The bounds are widened by one bit so x+W and y+H cannot wrap.
  // The scan position is also limited to the visible area.
  logic in_x, in_y;
  assign in_x = ({1'b0, px} >= {1'b0, x}) && ({1'b0, px} < ({1'b0, x} + 12'(BULLET_W)))
                && ({1'b0, px} < 12'(HRES));
  assign in_y = ({1'b0, py} >= {1'b0, y}) && ({1'b0, py} < ({1'b0, y} + 11'(BULLET_H)))
                && ({1'b0, py} < 11'(VRES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bullet_on <= 1'b0;
    else        bullet_on <= active && in_x && in_y;
  end

endmodule

// File: tb/tb_bullet_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bullet_ctrl
// Self-checking bench for bullet_ctrl. A directed sequence covers reset, spawn,
// render, stall, miss, hit/auto-fire and game_over. It is followed by
// randomized bullets, each checked against a trajectory model:
// y = 684 - 16*k, x = paddle_x + 23.
// -----------------------------------------------------------------------------
module tb_bullet_ctrl;
  import bullet_ctrl_pkg::*;

  localparam int SPAWN_Y = 720 - 20 - 16;  // 684
  localparam int OFS     = 50 / 2 - 4 / 2; // 23
  localparam int SPEED   = 16;
  localparam int CD      = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_tick, fire, game_over;
  logic [10:0] paddle_x;
  logic        hit_req;
  logic [10:0] hit_x;
  logic [9:0]  hit_y;
  logic        hit_ack, hit_kill;
  logic [10:0] px;
  logic [9:0]  py;
  logic        bullet_on, active;
  logic [15:0] shots;

  int tests = 0;
  int fails = 0;

  bullet_ctrl dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .fire(fire),
    .game_over(game_over), .paddle_x(paddle_x), .hit_req(hit_req),
    .hit_x(hit_x), .hit_y(hit_y), .hit_ack(hit_ack), .hit_kill(hit_kill),
    .px(px), .py(py), .bullet_on(bullet_on), .active(active), .shots(shots)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic ack(input logic kill);
    hit_ack  = 1'b1;
    hit_kill = kill;
    step();
    hit_ack  = 1'b0;
    hit_kill = 1'b0;
  endtask

  // Call right after the moving frame tick. Checks the query, stalls with
  // random (dropped) frame ticks, acks, and checks the result.
  task automatic do_move(input int ex, input int ey, input bit kill, input int stall);
    check("move_req", 32'(hit_req), 32'd1);
    check("move_hit_x", 32'(hit_x), 32'(ex));
    check("move_hit_y", 32'(hit_y), 32'(ey));
    for (int i = 0; i < stall; i++) begin
      frame_tick = ($urandom_range(0, 1) == 1);
      step();
      frame_tick = 1'b0;
    end
    check("stall_hit_y", 32'(hit_y), 32'(ey));
    check("stall_req", 32'(hit_req), 32'd1);
    ack(kill);
    check("ack_req_drop", 32'(hit_req), 32'd0);
    check("ack_active", 32'(active), kill ? 32'd0 : 32'd1);
    check("ack_y", 32'(dut.y), 32'(ey));
  endtask

  // COOLDOWN must last exactly CD frame ticks after entry.
  task automatic cooldown_wait();
    for (int i = 1; i <= CD; i++) begin
      frame();
      check("cd_active", 32'(active), 32'd0);
      check("cd_state", 32'(dut.state), (i < CD) ? 32'(COOLDOWN) : 32'(IDLE));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_shots;
    int ym;
    int moves;
    int pxl;
    bit kill;
    bit done;

    rst_n = 1'b0; frame_tick = 1'b0; fire = 1'b0; game_over = 1'b0;
    paddle_x = '0; hit_ack = 1'b0; hit_kill = 1'b0; px = '0; py = '0;
    repeat (3) step();

    // Reset state
    check("rst_hit_req", 32'(hit_req), 32'd0);
    check("rst_hit_x", 32'(hit_x), 32'd0);
    check("rst_hit_y", 32'(hit_y), 32'd0);
    check("rst_bullet_on", 32'(bullet_on), 32'd0);
    check("rst_active", 32'(active), 32'd0);
    check("rst_shots", 32'(shots), 32'd0);
    check("rst_state", 32'(dut.state), 32'(IDLE));
    rst_n = 1'b1;
    step();
    // The pixel at x=y=0 is inside the rectangle, but no bullet is active.
    check("idle_no_draw", 32'(bullet_on), 32'd0);
    // Stray ack in IDLE is ignored.
    ack(1'b0);
    check("idle_ack_state", 32'(dut.state), 32'(IDLE));

    // Spawn
    paddle_x = 11'd100; fire = 1'b1;
    frame();
    fire = 1'b0;
    check("spawn_x", 32'(dut.x), 32'd123);
    check("spawn_y", 32'(dut.y), 32'd684);
    check("spawn_active", 32'(active), 32'd1);
    check("spawn_shots", 32'(shots), 32'd1);
    check("spawn_no_req", 32'(hit_req), 32'd0);
    step();
    check("spawn_no_req2", 32'(hit_req), 32'd0);

    // First move: query at (123,668)
    frame();
    check("q1_req", 32'(hit_req), 32'd1);
    check("q1_hit_x", 32'(hit_x), 32'd123);
    check("q1_hit_y", 32'(hit_y), 32'd668);

    // Render sweep around (123,668) while the query is outstanding
    for (int yy = 664; yy < 688; yy++) begin
      for (int xx = 119; xx < 131; xx++) begin
        px = 11'(xx); py = 10'(yy);
        step();
        check("render", 32'(bullet_on),
              32'(xx >= 123 && xx < 127 && yy >= 668 && yy < 684));
      end
    end
    // One-cycle latency: output holds until the next edge.
    px = 11'd123; py = 10'd668;
    step();
    px = 11'd0; py = 10'd0;
    #2;
    check("render_latency_hold", 32'(bullet_on), 32'd1);
    step();
    check("render_latency_drop", 32'(bullet_on), 32'd0);

    // Stall across 3 frame ticks: coordinates frozen, no extra move
    for (int i = 0; i < 3; i++) begin
      frame();
      step();
    end
    check("stall_req_held", 32'(hit_req), 32'd1);
    check("stall_x", 32'(hit_x), 32'd123);
    check("stall_y", 32'(hit_y), 32'd668);
    ack(1'b0);
    check("stall_ack_req", 32'(hit_req), 32'd0);
    check("stall_ack_y", 32'(dut.y), 32'd668);
    check("stall_ack_active", 32'(active), 32'd1);

    // Miss path: climb to y=12 after 42 moves in total
    ym = 668; moves = 1;
    while (ym >= SPEED) begin
      step();
      frame();
      ym -= SPEED; moves++;
      do_move(123, ym, 1'b0, $urandom_range(0, 2));
    end
    check("miss_moves", 32'(moves), 32'd42);
    check("miss_y", 32'(dut.y), 32'd12);
    frame();
    check("exit_no_req", 32'(hit_req), 32'd0);
    check("exit_active", 32'(active), 32'd0);
    check("exit_state", 32'(dut.state), 32'(COOLDOWN));
    cooldown_wait();
    check("miss_shots", 32'(shots), 32'd1);

    // Hit at y=540, then auto-fire respawn with fire held
    paddle_x = 11'd200; fire = 1'b1;
    frame();
    check("hit_spawn_shots", 32'(shots), 32'd2);
    check("hit_spawn_x", 32'(dut.x), 32'd223);
    for (int k = 1; k <= 9; k++) begin
      frame();
      do_move(223, SPAWN_Y - SPEED * k, (k == 9), 1);
    end
    cooldown_wait();
    check("autofire_wait_shots", 32'(shots), 32'd2);
    frame();
    check("autofire_active", 32'(active), 32'd1);
    check("autofire_shots", 32'(shots), 32'd3);
    check("autofire_y", 32'(dut.y), 32'd684);
    fire = 1'b0;

    // game_over together with ack during QUERY
    frame();
    check("go_req_before", 32'(hit_req), 32'd1);
    game_over = 1'b1; hit_ack = 1'b1; hit_kill = 1'b0;
    step();
    hit_ack = 1'b0;
    check("go_req", 32'(hit_req), 32'd0);
    check("go_active", 32'(active), 32'd0);
    check("go_shots", 32'(shots), 32'd3);
    check("go_state", 32'(dut.state), 32'(IDLE));
    fire = 1'b1;
    frame();
    check("go_no_spawn", 32'(active), 32'd0);
    check("go_no_spawn_shots", 32'(shots), 32'd3);
    game_over = 1'b0;

    // Asynchronous reset during QUERY
    frame();
    fire = 1'b0;
    check("pre_rst_shots", 32'(shots), 32'd4);
    frame();
    check("pre_rst_req", 32'(hit_req), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_req", 32'(hit_req), 32'd0);
    check("async_rst_active", 32'(active), 32'd0);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    check("post_rst_state", 32'(dut.state), 32'(IDLE));
    check("post_rst_shots", 32'(shots), 32'd0);

    // Randomized bullets against the trajectory model
    exp_shots = 0;
    for (int b = 0; b < 5; b++) begin
      pxl = $urandom_range(0, 1280 - 50);
      paddle_x = 11'(pxl);
      repeat ($urandom_range(0, 3)) step();
      fire = 1'b1;
      frame();
      fire = 1'b0;
      exp_shots++;
      check("rnd_shots", 32'(shots), 32'(exp_shots));
      check("rnd_spawn_x", 32'(dut.x), 32'(pxl + OFS));
      check("rnd_spawn_y", 32'(dut.y), 32'(SPAWN_Y));
      ym = SPAWN_Y;
      done = 1'b0;
      while (!done) begin
        if ($urandom_range(0, 3) == 0) begin
          ack(1'b1);  // stray ack in FLY must be ignored
          check("rnd_stray_active", 32'(active), 32'd1);
          check("rnd_stray_req", 32'(hit_req), 32'd0);
        end
        frame();
        if (ym < SPEED) begin
          check("rnd_exit_active", 32'(active), 32'd0);
          check("rnd_exit_req", 32'(hit_req), 32'd0);
          cooldown_wait();
          done = 1'b1;
        end else begin
          ym -= SPEED;
          kill = ($urandom_range(0, 9) == 0);
          do_move(pxl + OFS, ym, kill, $urandom_range(0, 3));
          if (kill) begin
            cooldown_wait();
            done = 1'b1;
          end
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
